sc_life_event_controller: RTL



---
 rtl/sc_life_event_controller_pkg.sv | 28 ++
 rtl/sc_life_event_controller_edge_detect.sv | 21 ++
 rtl/sc_life_event_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sc_life_event_controller_pkg.sv
// Shared types and constants for the life-counter command controller.
// INIT_LIVES must track the life counter's clear value.
package sc_life_event_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_BONUS    = 3'd3,
        ST_HIT      = 3'd4,
        ST_SETTLE   = 3'd5,
        ST_RESPAWN  = 3'd6,
        ST_GAMEOVER = 3'd7
    } state_e;

    // Counter command encoding is active-low: a zero bit selects the action.
    localparam logic [1:0] CMD_DEC  = 2'b10;
    localparam logic [1:0] CMD_INC  = 2'b01;
    localparam logic [1:0] CMD_HOLD = 2'b11;

    localparam int INIT_LIVES = 3;

    function automatic logic isPlayingState(input state_e s);
        return (s == ST_PLAY)   || (s == ST_BONUS) || (s == ST_HIT) ||
               (s == ST_SETTLE) || (s == ST_RESPAWN);
    endfunction

endpackage

// File: rtl/sc_life_event_controller_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse when the input goes 0 -> 1.
module sc_edge_detect (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_level,
    output logic o_pulse
);

    logic r_level;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_level <= 1'b0;
        end else begin
            r_level <= i_level;
        end
    end

    assign o_pulse = i_level & ~r_level;

endmodule

// File: rtl/sc_life_event_controller.sv
// Turns collision/bonus/start edges into single-cycle active-low life-counter
// commands, with a post-hit respawn window, a life ceiling and game-over detection.
module sc_life_event_controller
    import sc_life_event_controller_pkg::*;
#(
    parameter int DATAWIDTH      = 8,
    parameter int MAX_LIVES      = 5,
    parameter int RESPAWN_CYCLES = 50000000
) (
    input  logic                 SC_upLIFECOUNTER_CLOCK_50,
    input  logic                 SC_upLIFECOUNTER_RESET_InHigh,
    input  logic                 start_InHigh,
    input  logic                 collision_InHigh,
    input  logic                 bonus_InHigh,
    input  logic [DATAWIDTH-1:0] lives_InBUS,
    output logic [1:0]           upcount_OutLow,
    output logic                 clear_OutLow,
    output logic                 respawn_OutHigh,
    output logic                 playing_OutHigh,
    output logic                 gameover_OutHigh
);

    localparam int                      TIMERWIDTH    = $clog2(RESPAWN_CYCLES + 1);
    localparam logic [TIMERWIDTH-1:0]   TIMER_LOAD    = TIMERWIDTH'(RESPAWN_CYCLES - 1);
    localparam logic [DATAWIDTH-1:0]    LIVES_CEILING = DATAWIDTH'(MAX_LIVES);

    state_e                  r_state;
    state_e                  w_stateNext;
    logic [TIMERWIDTH-1:0]   r_timer;
    logic [TIMERWIDTH-1:0]   w_timerNext;
    logic                    w_startPulse;
    logic                    w_collisionPulse;
    logic                    w_bonusPulse;
    logic                    w_livesZero;

    sc_edge_detect u_startEdge (
        .i_clock (SC_upLIFECOUNTER_CLOCK_50),
        .i_reset (SC_upLIFECOUNTER_RESET_InHigh),
        .i_level (start_InHigh),
        .o_pulse (w_startPulse)
    );

    sc_edge_detect u_collisionEdge (
        .i_clock (SC_upLIFECOUNTER_CLOCK_50),
        .i_reset (SC_upLIFECOUNTER_RESET_InHigh),
        .i_level (collision_InHigh),
        .o_pulse (w_collisionPulse)
    );

    sc_edge_detect u_bonusEdge (
        .i_clock (SC_upLIFECOUNTER_CLOCK_50),
        .i_reset (SC_upLIFECOUNTER_RESET_InHigh),
        .i_level (bonus_InHigh),
        .o_pulse (w_bonusPulse)
    );

    assign w_livesZero = (lives_InBUS == '0);

    // Collision outranks bonus in PLAY, so a simultaneous bonus is simply dropped.
    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        case (r_state)
            ST_IDLE: begin
                if (w_startPulse) w_stateNext = ST_START;
            end
            ST_START: begin
                w_stateNext = ST_PLAY;
            end
            ST_PLAY: begin
                if (w_livesZero)           w_stateNext = ST_GAMEOVER;
                else if (w_collisionPulse) w_stateNext = ST_HIT;
                else if (w_bonusPulse)     w_stateNext = ST_BONUS;
            end
            ST_BONUS: begin
                w_stateNext = ST_PLAY;
            end
            ST_HIT: begin
                w_stateNext = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_livesZero) begin
                    w_stateNext = ST_GAMEOVER;
                end else begin
                    w_timerNext = TIMER_LOAD;
                    w_stateNext = ST_RESPAWN;
                end
            end
            ST_RESPAWN: begin
                if (r_timer == '0) w_stateNext = ST_PLAY;
                else               w_timerNext = r_timer - TIMERWIDTH'(1);
            end
            ST_GAMEOVER: begin
                if (w_startPulse) w_stateNext = ST_START;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SC_upLIFECOUNTER_CLOCK_50 or posedge SC_upLIFECOUNTER_RESET_InHigh) begin
        if (SC_upLIFECOUNTER_RESET_InHigh) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_stateNext;
            r_timer <= w_timerNext;
        end
    end

    always_comb begin
        upcount_OutLow = CMD_HOLD;
        case (r_state)
            ST_BONUS: upcount_OutLow = (lives_InBUS < LIVES_CEILING) ? CMD_INC : CMD_HOLD;
            ST_HIT:   upcount_OutLow = CMD_DEC;
            default:  upcount_OutLow = CMD_HOLD;
        endcase
    end

    assign clear_OutLow     = (r_state != ST_START);
    assign respawn_OutHigh  = (r_state == ST_RESPAWN);
    assign gameover_OutHigh = (r_state == ST_GAMEOVER);
    assign playing_OutHigh  = isPlayingState(r_state);

endmodule
